// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between four byte-stream requesters.
// A grant is held for a whole message, so messages never interleave on the wire.
module uart_tx_arbiter #(
    parameter logic [15:0] hold_timeout = 16'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        timeout_event
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  owner, owner_nx;
    logic        last_flag, last_flag_nx;
    logic [15:0] timer, timer_nx;
    logic [3:0]  grant_nx;
    logic [7:0]  tx_data_nx;
    logic        tx_wr_nx;
    logic        timeout_nx;

    logic [1:0]  win;
    logic        win_vld;
    logic [1:0]  cand;
    logic [1:0]  xfer_idx;
    logic        xfer;

    // Scan from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req_valid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        case (state)
            IDLE:    if (win_vld) req_ready = 4'b0001 << win;
            HOLD:    req_ready = grant;
            default: req_ready = '0;
        endcase
    end

    assign xfer     = |(req_valid & req_ready);
    assign xfer_idx = (state == IDLE) ? win : owner;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        owner_nx     = owner;
        last_flag_nx = last_flag;
        timer_nx     = timer;
        grant_nx     = grant;
        tx_data_nx   = tx_data;
        tx_wr_nx     = 1'b0;
        timeout_nx   = 1'b0;

        if ((state == IDLE || state == HOLD) && xfer) begin
            state_nx     = WAIT;
            owner_nx     = xfer_idx;
            grant_nx     = 4'b0001 << xfer_idx;
            tx_data_nx   = req_data[{xfer_idx, 3'b000} +: 8];
            tx_wr_nx     = 1'b1;
            last_flag_nx = req_last[xfer_idx];
        end else begin
            case (state)
                // tx_done coinciding with the start pulse belongs to no byte of ours
                WAIT: begin
                    if (tx_done && !tx_wr) begin
                        if (last_flag) begin
                            grant_nx = '0;
                            ptr_nx   = owner;
                            state_nx = IDLE;
                        end else begin
                            timer_nx = '0;
                            state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_timeout != 16'd0 && timer == hold_timeout - 16'd1) begin
                        grant_nx   = '0;
                        ptr_nx     = owner;
                        timeout_nx = 1'b1;
                        state_nx   = IDLE;
                    end else if (timer != 16'hFFFF) begin
                        timer_nx = timer + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            ptr           <= 2'd3;
            owner         <= 2'd0;
            last_flag     <= 1'b0;
            timer         <= '0;
            grant         <= '0;
            tx_data       <= '0;
            tx_wr         <= 1'b0;
            timeout_event <= 1'b0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            owner         <= owner_nx;
            last_flag     <= last_flag_nx;
            timer         <= timer_nx;
            grant         <= grant_nx;
            tx_data       <= tx_data_nx;
            tx_wr         <= tx_wr_nx;
            timeout_event <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: each expected byte/grant is queued when stimulus is
// driven and compared when the arbiter pulses tx_wr.
module tb_uart_tx_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_event;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    logic lock_mon = 1'b0;
    logic r1_leak = 1'b0;

    uart_tx_arbiter #(.hold_timeout(16'd8)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_done      (tx_done),
        .grant        (grant),
        .busy         (busy),
        .timeout_event(timeout_event)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    // Called from a tx_wr cycle: wait one WAIT cycle, then pulse tx_done.
    task automatic complete();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (tx_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spare_wr", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, tx_data}, {24'd0, e.d});
                chk("sb_grant", {28'd0, grant}, {28'd0, e.g});
            end
        end
        if (lock_mon && req_ready[1] === 1'b1) r1_leak = 1'b1;
    end

    initial begin
        sys_rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        step(); step();
        sys_rst = 1'b0;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr", {31'd0, tx_wr}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_to", {31'd0, timeout_event}, 32'd0);

        // single byte
        req_data[7:0] = 8'h41; req_last = 4'b0001; req_valid = 4'b0001;
        push(8'h41, 4'b0001);
        #1;
        chk("sb_ready", {28'd0, req_ready}, 32'h1);
        step();
        chk("sb_wr", {31'd0, tx_wr}, 32'd1);
        chk("sb_busy", {31'd0, busy}, 32'd1);
        req_valid = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("done_with_wr_ignored", {28'd0, grant}, 32'h1);
        chk("sb_wr_once", {31'd0, tx_wr}, 32'd0);
        repeat (98) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("sb_end_grant", {28'd0, grant}, 32'd0);
        chk("sb_end_busy", {31'd0, busy}, 32'd0);

        // spurious tx_done in IDLE
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("spur_grant", {28'd0, grant}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        chk("spur_wr", {31'd0, tx_wr}, 32'd0);
        chk("spur_data", {24'd0, tx_data}, 32'h41);

        // round robin after reset: 0,1,2,3,0
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        req_data = 32'h13121110; req_last = 4'hF; req_valid = 4'hF;
        push(8'h10, 4'b0001); push(8'h11, 4'b0010); push(8'h12, 4'b0100);
        push(8'h13, 4'b1000); push(8'h10, 4'b0001);
        step();
        chk("rr_wr0", {31'd0, tx_wr}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            complete();
            chk("rr_gap", {31'd0, tx_wr}, 32'd0);
            step();
            chk("rr_wr", {31'd0, tx_wr}, 32'd1);
        end
        req_valid = '0;
        complete();
        chk("rr_idle", {31'd0, busy}, 32'd0);

        // one byte from requester 1 so the pointer favours requester 2 next
        req_data[15:8] = 8'h51; req_last = 4'b0010; req_valid = 4'b0010;
        push(8'h51, 4'b0010);
        step();
        chk("r1_wr", {31'd0, tx_wr}, 32'd1);
        req_valid = '0;
        complete();

        // message lock: requester 2 sends A0..A2 while requester 1 waits
        req_data = 32'h00A0B100; req_last = 4'b0010; req_valid = 4'b0110;
        lock_mon = 1'b1;
        push(8'hA0, 4'b0100); push(8'hA1, 4'b0100); push(8'hA2, 4'b0100);
        push(8'hB1, 4'b0010);
        step();
        chk("lock_a0", {31'd0, tx_wr}, 32'd1);
        req_data[23:16] = 8'hA1;
        complete();
        chk("hold_ready", {28'd0, req_ready}, 32'h4);
        step();
        chk("lock_a1", {31'd0, tx_wr}, 32'd1);
        req_data[23:16] = 8'hA2; req_last = 4'b0110;
        complete();
        step();
        chk("lock_a2", {31'd0, tx_wr}, 32'd1);
        req_valid = 4'b0010;
        lock_mon = 1'b0;
        complete();
        step();
        chk("lock_b1", {31'd0, tx_wr}, 32'd1);
        chk("r1_ready_leak", {31'd0, r1_leak}, 32'd0);
        req_valid = '0;
        complete();
        chk("lock_idle", {31'd0, busy}, 32'd0);

        // timeout after 8 idle HOLD cycles, requester 0 picks up at once
        req_data[31:24] = 8'hC3; req_last = 4'b0000; req_valid = 4'b1000;
        push(8'hC3, 4'b1000);
        step();
        chk("to_wr", {31'd0, tx_wr}, 32'd1);
        req_data[7:0] = 8'hD0; req_last = 4'b0001; req_valid = 4'b0001;
        push(8'hD0, 4'b0001);
        complete();
        chk("to_hold_grant", {28'd0, grant}, 32'h8);
        repeat (7) step();
        chk("to_h7_grant", {28'd0, grant}, 32'h8);
        chk("to_h7_event", {31'd0, timeout_event}, 32'd0);
        step();
        chk("to_grant", {28'd0, grant}, 32'd0);
        chk("to_event", {31'd0, timeout_event}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_ready0", {28'd0, req_ready}, 32'h1);
        step();
        chk("to_r0_wr", {31'd0, tx_wr}, 32'd1);
        chk("to_event_once", {31'd0, timeout_event}, 32'd0);
        req_valid = '0;
        complete();

        // reset during WAIT
        req_data[23:16] = 8'hE2; req_last = 4'b0100; req_valid = 4'b0100;
        push(8'hE2, 4'b0100);
        step();
        chk("rw_wr", {31'd0, tx_wr}, 32'd1);
        req_valid = '0;
        sys_rst = 1'b1;
        step();
        chk("rw_grant", {28'd0, grant}, 32'd0);
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_wr0", {31'd0, tx_wr}, 32'd0);
        chk("rw_data", {24'd0, tx_data}, 32'd0);
        chk("rw_to", {31'd0, timeout_event}, 32'd0);
        sys_rst = 1'b0;
        req_data[7:0] = 8'hF0; req_last = 4'b0101; req_valid = 4'b0101;
        push(8'hF0, 4'b0001);
        #1;
        chk("rw_ready0", {28'd0, req_ready}, 32'h1);
        step();
        chk("rw_r0_wr", {31'd0, tx_wr}, 32'd1);
        req_valid = '0;
        complete();
        chk("rw_idle", {31'd0, busy}, 32'd0);

        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit path of one `uart_transceiver` between four byte-stream requesters, such as the CPU console, a debug monitor, a trace dumper and a boot loader. Grants are round-robin and held for a whole message (until `req_last`), so messages never interleave on the wire. The block drives the transceiver's `tx_data`/`tx_wr` and sequences on `tx_done`; it sits between the requesters and the transceiver, in place of the direct CSR write path.

## Interface
- `hold_timeout`, default 16'd1024: idle cycles allowed inside a message before the grant is revoked; 0 = never revoke.
- `sys_clk`  in  1  clock; all logic is on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  4  requester i has a byte available.
- `req_data`  in  32  byte of requester i on bits [8i+7:8i].
- `req_last`  in  4  byte of requester i ends its message.
- `req_ready`  out  4  combinational; at most one bit set. A byte transfers on a cycle where `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  byte to the transceiver; held stable until the next transfer.
- `tx_wr`  out  1  one-cycle start pulse to the transceiver.
- `tx_done`  in  1  one-cycle pulse from the transceiver when a byte has been sent.
- `grant`  out  4  one-hot owner of the UART, or 0 when no one owns it.
- `busy`  out  1  high when the state is not IDLE.
- `timeout_event`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- The state machine has three states: IDLE, WAIT, HOLD. Registers: `ptr` (2 bits, last served requester), `last_flag`, 16-bit `timer`.
- **IDLE**
  - Winner = first i with `req_valid[i]`, searching `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4).
  - `req_ready` = one-hot of the winner, or 0 if nothing is valid.
  - On transfer: `grant` <= winner, `tx_data` <= byte, `tx_wr` <= 1, `last_flag` <= `req_last[winner]`, go to WAIT.
- **WAIT**
  - `req_ready` = 0. `tx_wr` is high only in the first WAIT cycle.
  - On `tx_done` with `last_flag` = 1: `grant` <= 0, `ptr` <= granted index, go to IDLE.
  - On `tx_done` with `last_flag` = 0: `timer` <= 0, go to HOLD.
- **HOLD**
  - `req_ready` = `grant`.
  - On transfer by the owner: same register updates as the IDLE transfer (`grant` unchanged), go to WAIT.
  - Otherwise `timer` increments.
  - If `hold_timeout` != 0 and `timer` == `hold_timeout`-1 with no transfer that cycle: `grant` <= 0, `ptr` <= owner, `timeout_event` <= 1, go to IDLE.
- **Ignored inputs:**
  - `tx_done` in IDLE or HOLD is spurious and ignored.
  - `tx_done` in the same cycle that `tx_wr` is high is ignored.
- Other requesters' `req_valid` never affects an active grant.
- Requesters other than the owner see `req_ready` = 0 in every state except IDLE.
- `req_data`/`req_last` are sampled only on transfer; there is no internal buffering beyond `tx_data`.

## Timing
- Reset (synchronous) forces state IDLE, `tx_wr` = 0, `tx_data` = 0, `grant` = 0, `busy` = 0, `timeout_event` = 0, `ptr` = 3, `timer` = 0, `last_flag` = 0. Reset asserted mid-message aborts the message immediately.
- Transfer at edge E: `tx_wr` = 1 and `tx_data` valid during cycle E+1 only; `busy` = 1 from E+1.
- `tx_done` at cycle D in WAIT:
  - Last byte: IDLE from D+1, next transfer possible in D+1, its `tx_wr` in D+2.
  - Non-last byte: HOLD from D+1; the owner can transfer in D+1.
- Timeout: with the owner idle throughout, IDLE is entered exactly `hold_timeout` cycles after HOLD entry; `timeout_event` is high in the first IDLE cycle.
- A transfer in the same cycle as the timeout condition wins: no revoke.
- `timer` is 16 bits and never wraps: it stops counting at timeout.

## Test plan
- **Single byte:** reset; `req_valid` = 4'b0001, `req_data[7:0]` = 8'h41, `req_last[0]` = 1.
  - Response: `tx_wr` pulses once with `tx_data` = 8'h41 one cycle after the transfer; `grant` = 4'b0001.
  - Drive `tx_done` 100 cycles later: `grant` = 0 and `busy` = 0 the next cycle.
- **Round robin:** all four valid continuously with single-byte messages 8'h10..8'h13.
  - Response: service order 0, 1, 2, 3, 0.
  - Each `tx_wr` follows the previous `tx_done` by exactly 2 cycles.
- **Message lock:** requester 2 sends 8'hA0, 8'hA1, 8'hA2 (last on 8'hA2) while requester 1 is valid throughout.
  - Response: all three bytes precede any byte of requester 1; `req_ready[1]` = 0 for the whole message.
- **Timeout:** `hold_timeout` = 8; requester 3 sends a non-last byte, then drops valid.
  - Response: `grant` clears and `timeout_event` pulses 8 cycles after HOLD entry.
  - Requester 0 valid at the same time is granted in the first IDLE cycle.
- **Spurious and reset:**
  - A `tx_done` pulse in IDLE produces no output change.
  - Asserting `sys_rst` during WAIT gives all outputs at their reset values next cycle, and the next grant goes to requester 0.
